// File: rtl/lm75_pkg.sv
// lm75_pkg: shared constants for the LM75 I2C responder.
//   DEV_ADDR_DFLT          default 7-bit target address
//   PTR_TEMP..PTR_TOS      pointer register codes
//   THYST_RST / TOS_RST    power-on limit values (75 C / 80 C)
//   state_t                responder FSM state encoding
package lm75_pkg;

    localparam logic [6:0]  DEV_ADDR_DFLT = 7'h48;

    localparam logic [1:0]  PTR_TEMP  = 2'd0;
    localparam logic [1:0]  PTR_CONF  = 2'd1;
    localparam logic [1:0]  PTR_THYST = 2'd2;
    localparam logic [1:0]  PTR_TOS   = 2'd3;

    localparam logic [15:0] THYST_RST = 16'h4B00;
    localparam logic [15:0] TOS_RST   = 16'h5000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK
    } state_t;

endpackage

// File: rtl/lm75_i2c_responder_line_sync.sv
// i2c_line_sync: two-flop synchronizers plus a history flop on SCL and SDA,
// producing single-cycle bus event pulses.
//   clk, rst              system clock, synchronous active-high reset
//   scl_i, sda_i          raw pad levels (asynchronous)
//   scl_rise, scl_fall    SCL edge pulses
//   start_det, stop_det   START / STOP pulses (SDA edge while SCL high)
//   sda_s                 synchronized SDA level
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
    logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;

    always_comb begin
        scl_meta_d = scl_i;
        scl_sync_d = scl_meta_q;
        scl_hist_d = scl_sync_q;
        sda_meta_d = sda_i;
        sda_sync_d = sda_meta_q;
        sda_hist_d = sda_sync_q;
    end

    // Reset to the idle-bus level so leaving reset never fakes an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_rise  =  scl_sync_q & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q &  scl_hist_q;
    // SCL must be high in both samples so an SCL edge coinciding with an
    // SDA change is not mistaken for START/STOP.
    assign start_det =  scl_sync_q &  scl_hist_q &  sda_hist_q & ~sda_sync_q;
    assign stop_det  =  scl_sync_q &  scl_hist_q & ~sda_hist_q &  sda_sync_q;
    assign sda_s     =  sda_sync_q;

endmodule

// File: rtl/lm75_i2c_responder.sv
// lm75_i2c_responder: I2C target emulating an LM75 temperature sensor.
//   DEV_ADDR      7-bit target address
//   clk, rst      system clock (>= 16x SCL), synchronous active-high reset
//   scl_i, sda_i  raw bus lines
//   temp_i        LM75-format temperature word ([6:0] ignored)
//   sda_oe        1 = pull SDA low
//   busy          high from address match until STOP/START/NACK
//   os_o          over-temperature output (only with LM75_OS_EN defined)
// Optional feature macro: LM75_OS_EN (THYST/TOS registers + comparator).
//
// state        | meaning
// ST_IDLE      | not addressed, waiting for START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving address ACK
// ST_PTR       | shifting in pointer byte
// ST_PTR_ACK   | driving pointer ACK
// ST_WDATA     | shifting in register write byte
// ST_WDATA_ACK | driving write-data ACK
// ST_RDATA     | shifting out register byte
// ST_RACK      | initiator ACK/NACK slot
module lm75_i2c_responder
    import lm75_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    input  logic [15:0] temp_i,
    output logic        sda_oe,
    output logic        busy
`ifdef LM75_OS_EN
    ,
    output logic        os_o
`endif
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic [1:0] ptr_q, ptr_d;
    logic       rd_idx_q, rd_idx_d;
    logic [1:0] wr_idx_q, wr_idx_d;
    logic       mack_q, mack_d;
    logic [8:0] snap_q, snap_d;     // temp_i[15:7]; low bits always read 0
    logic [7:0] conf_q, conf_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
`ifdef LM75_OS_EN
    logic [8:0] thyst_q, thyst_d;   // limit registers keep only [15:7]
    logic [8:0] tos_q, tos_d;
    logic       flag_q, flag_d;
    logic       os_q, os_d;
`endif

    logic unused_temp_lsbs;
    assign unused_temp_lsbs = ^temp_i[6:0];

    function automatic logic [7:0] reg_byte(input logic [1:0] p, input logic idx);
        logic [7:0] b;
        b = 8'h00;
        case (p)
            PTR_TEMP:  b = idx ? {snap_q[0], 7'b0} : snap_q[8:1];
            PTR_CONF:  b = conf_q;
`ifdef LM75_OS_EN
            PTR_THYST: b = idx ? {thyst_q[0], 7'b0} : thyst_q[8:1];
            PTR_TOS:   b = idx ? {tos_q[0], 7'b0} : tos_q[8:1];
`endif
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        rd_idx_d  = rd_idx_q;
        wr_idx_d  = wr_idx_q;
        mack_d    = mack_q;
        snap_d    = snap_q;
        conf_d    = conf_q;
        sda_oe_d  = sda_oe_q;
`ifdef LM75_OS_EN
        thyst_d   = thyst_q;
        tos_d     = tos_q;
`endif
        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (shreg_d[7:1] == DEV_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = shreg_d[0];
                                    if (shreg_d[0]) snap_d = temp_i[15:7];
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = shreg_d[1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                case (ptr_q)
                                    PTR_CONF:  if (wr_idx_q == 2'd0) conf_d = shreg_d;
`ifdef LM75_OS_EN
                                    PTR_THYST: begin
                                        if (wr_idx_q == 2'd0)      thyst_d[8:1] = shreg_d;
                                        else if (wr_idx_q == 2'd1) thyst_d[0]   = shreg_d[7];
                                    end
                                    PTR_TOS: begin
                                        if (wr_idx_q == 2'd0)      tos_d[8:1] = shreg_d;
                                        else if (wr_idx_q == 2'd1) tos_d[0]   = shreg_d[7];
                                    end
`endif
                                    default: ;
                                endcase
                                if (wr_idx_q != 2'd2) wr_idx_d = wr_idx_q + 2'd1;
                                state_d = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // ACK states: first fall drives ACK, second fall ends the slot.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = 3'd0;
                            sda_oe_d  = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d  = ST_RDATA;
                                rd_idx_d = 1'b0;
                                tx_d     = reg_byte(ptr_q, 1'b0);
                                sda_oe_d = ~tx_d[7];
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                if (state_q == ST_PTR_ACK) wr_idx_d = 2'd0;
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RACK;
                            mack_d  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d  = ST_IDLE;
                            sda_oe_d = 1'b0;
                        end else begin
                            mack_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            // Config is one byte wide, so its index never advances.
                            rd_idx_d  = (ptr_q == PTR_CONF) ? 1'b0 : ~rd_idx_q;
                            tx_d      = reg_byte(ptr_q, rd_idx_d);
                            sda_oe_d  = ~tx_d[7];
                            bit_cnt_d = 3'd0;
                            mack_d    = 1'b0;
                            state_d   = ST_RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_ADDR);
    end

`ifdef LM75_OS_EN
    always_comb begin
        flag_d = flag_q;
        if ($signed(temp_i[15:7]) >= $signed(tos_q))
            flag_d = 1'b1;
        else if ($signed(temp_i[15:7]) < $signed(thyst_q))
            flag_d = 1'b0;
        os_d = flag_d ^ conf_q[2];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            tx_q      <= 8'h00;
            rw_q      <= 1'b0;
            ptr_q     <= PTR_TEMP;
            rd_idx_q  <= 1'b0;
            wr_idx_q  <= 2'd0;
            mack_q    <= 1'b0;
            snap_q    <= 9'h000;
            conf_q    <= 8'h00;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef LM75_OS_EN
            thyst_q   <= THYST_RST[15:7];
            tos_q     <= TOS_RST[15:7];
            flag_q    <= 1'b0;
            os_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            rd_idx_q  <= rd_idx_d;
            wr_idx_q  <= wr_idx_d;
            mack_q    <= mack_d;
            snap_q    <= snap_d;
            conf_q    <= conf_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
`ifdef LM75_OS_EN
            thyst_q   <= thyst_d;
            tos_q     <= tos_d;
            flag_q    <= flag_d;
            os_q      <= os_d;
`endif
        end
    end

    assign sda_oe = sda_oe_q;
    assign busy   = busy_q;
`ifdef LM75_OS_EN
    assign os_o   = os_q;
`endif

endmodule
